// File: rtl/fifo_port_arbiter_if.sv
// Bundle of requester-side and FIFO-side signals around the FIFO port arbiter.
// The arbiter uses the slave modport; requesters and the FIFO together form the master side.
interface fifo_port_arbiter_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) ();
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic             wr0_req;
  logic             wr1_req;
  logic [WIDTH-1:0] wr0_data;
  logic [WIDTH-1:0] wr1_data;
  logic             rd_req;
  logic             wr0_gnt;
  logic             wr1_gnt;
  logic             rd_valid;
  logic [WIDTH-1:0] rd_data;
  logic             fifo_en_in;
  logic             fifo_en_out;
  logic [WIDTH-1:0] fifo_din;
  logic [WIDTH-1:0] fifo_dout;
  logic [CntW-1:0]  fifo_count;

  modport slave (
    input  wr0_req, wr1_req, wr0_data, wr1_data, rd_req, fifo_dout, fifo_count,
    output wr0_gnt, wr1_gnt, rd_valid, rd_data, fifo_en_in, fifo_en_out, fifo_din
  );

  modport master (
    output wr0_req, wr1_req, wr0_data, wr1_data, rd_req, fifo_dout, fifo_count,
    input  wr0_gnt, wr1_gnt, rd_valid, rd_data, fifo_en_in, fifo_en_out, fifo_din
  );
endinterface

// File: rtl/fifo_port_arbiter.sv
// Round-robin sharing of one FIFO between two writers and one reader.
// Each operation is IDLE (decide) -> OP (strobe) -> SETTLE (FIFO count/data update).
module fifo_port_arbiter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  fifo_port_arbiter_if.slave  bus
);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

  localparam logic [1:0] PtrWr0 = 2'd0;
  localparam logic [1:0] PtrWr1 = 2'd1;
  localparam logic [1:0] PtrRd  = 2'd2;

  typedef enum logic [1:0] {
    StIdle,
    StOp,
    StSettle
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic             op_rd_q, op_rd_d;
  logic             wr0_gnt_q, wr0_gnt_d;
  logic             wr1_gnt_q, wr1_gnt_d;
  logic             en_in_q, en_in_d;
  logic             en_out_q, en_out_d;
  logic             rd_valid_q, rd_valid_d;
  logic [WIDTH-1:0] din_q, din_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;

  logic [3:0]       elig;
  logic             win_vld;
  logic [1:0]       win_idx;
  logic [1:0]       cand;

  function automatic logic [1:0] rr_next(input logic [1:0] p);
    return (p == PtrWr0) ? PtrWr1 : (p == PtrWr1) ? PtrRd : PtrWr0;
  endfunction

  // Bit 3 stays zero so an out-of-range pointer value never selects anything.
  always_comb begin
    elig    = 4'b0000;
    elig[0] = bus.wr0_req && (bus.fifo_count < DepthCnt);
    elig[1] = bus.wr1_req && (bus.fifo_count < DepthCnt);
    elig[2] = bus.rd_req && (bus.fifo_count != '0);
  end

  // Scan from the pointer in wr0 -> wr1 -> rd order, skipping ineligible requesters.
  always_comb begin
    win_vld = 1'b0;
    win_idx = PtrWr0;
    cand    = (ptr_q == 2'd3) ? PtrWr0 : ptr_q;
    for (int k = 0; k < 3; k++) begin
      if (!win_vld && elig[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
      cand = rr_next(cand);
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    op_rd_d    = op_rd_q;
    wr0_gnt_d  = 1'b0;
    wr1_gnt_d  = 1'b0;
    en_in_d    = 1'b0;
    en_out_d   = 1'b0;
    rd_valid_d = 1'b0;
    din_d      = din_q;
    rd_data_d  = rd_data_q;
    unique case (state_q)
      StIdle: begin
        if (win_vld) begin
          state_d = StOp;
          ptr_d   = rr_next(win_idx);
          op_rd_d = (win_idx == PtrRd);
          unique case (win_idx)
            PtrWr0: begin
              en_in_d   = 1'b1;
              wr0_gnt_d = 1'b1;
              din_d     = bus.wr0_data;
            end
            PtrWr1: begin
              en_in_d   = 1'b1;
              wr1_gnt_d = 1'b1;
              din_d     = bus.wr1_data;
            end
            default: en_out_d = 1'b1;
          endcase
        end
      end
      StOp: begin
        state_d = StSettle;
      end
      StSettle: begin
        state_d = StIdle;
        // fifo_dout already holds the popped word by this cycle.
        if (op_rd_q) begin
          rd_data_d  = bus.fifo_dout;
          rd_valid_d = 1'b1;
          op_rd_d    = 1'b0;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      ptr_q      <= PtrWr0;
      op_rd_q    <= 1'b0;
      wr0_gnt_q  <= 1'b0;
      wr1_gnt_q  <= 1'b0;
      en_in_q    <= 1'b0;
      en_out_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      din_q      <= '0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      op_rd_q    <= op_rd_d;
      wr0_gnt_q  <= wr0_gnt_d;
      wr1_gnt_q  <= wr1_gnt_d;
      en_in_q    <= en_in_d;
      en_out_q   <= en_out_d;
      rd_valid_q <= rd_valid_d;
      din_q      <= din_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign bus.wr0_gnt     = wr0_gnt_q;
  assign bus.wr1_gnt     = wr1_gnt_q;
  assign bus.fifo_en_in  = en_in_q;
  assign bus.fifo_en_out = en_out_q;
  assign bus.fifo_din    = din_q;
  assign bus.rd_valid    = rd_valid_q;
  assign bus.rd_data     = rd_data_q;
endmodule
